// File: rtl/iq_result_readout_pkg.sv
// Shared register map, STATUS/CTRL field positions and defaults for the IQ
// result readout block and its FIFO.
package iq_result_readout_pkg;

    localparam int unsigned DEPTH_DEFAULT = 16;

    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_HEAD_I = 2'd1;
    localparam logic [1:0] OFF_HEAD_Q = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int unsigned STAT_VALID_BIT = 32;
    localparam int unsigned STAT_SEQ_LSB   = 24;
    localparam int unsigned STAT_OVF_BIT   = 16;
    localparam int unsigned STAT_COUNT_LSB = 0;

    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_OVF_CLR_BIT = 1;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] q;
    } iq_sample_t;

    function automatic logic [32:0] pack_status(input logic [7:0] seq,
                                                input logic ovf,
                                                input logic [15:0] count);
        logic [32:0] s;
        s = '0;
        s[STAT_VALID_BIT] = 1'b1;
        s[STAT_SEQ_LSB +: 8] = seq;
        s[STAT_OVF_BIT] = ovf;
        s[STAT_COUNT_LSB +: 16] = count;
        return s;
    endfunction

endpackage

// File: rtl/iq_result_readout_fifo.sv
// Single-clock 64-bit FIFO holding {I,Q} pairs; caller guarantees no push
// into a full FIFO unless a pop happens in the same cycle.
module iq_fifo
    import iq_result_readout_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [63:0]   din,
    output logic [63:0]   dout,
    output logic [CW-1:0] count
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only pointers define contents.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/iq_result_readout.sv
// Host-readable result FIFO for demodulated IQ samples: STATUS / HEAD_I /
// HEAD_Q (popping) / CTRL window on the PcPort MEM bus.
module iq_result_readout
    import iq_result_readout_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEFAULT,
    parameter logic [13:0] BASE_ADDR = 14'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iq_valid,
    input  logic [31:0] i_val,
    input  logic [31:0] q_val,
    input  logic [13:0] MEM_sdi_mem_S_address,
    input  logic        MEM_sdi_mem_S_rdEn,
    input  logic        MEM_sdi_mem_S_wrEn,
    input  logic [32:0] MEM_sdi_mem_S_wrData,
    output logic [32:0] MEM_sdi_mem_M_rdData,
    output logic        data_ready,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [13:0]   offset;
    logic          in_window;
    logic [1:0]    reg_sel;
    logic          ctrl_wr;
    logic          flush;
    logic          ovf_clr;
    logic          head_q_rd;
    logic          not_empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovf_event;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [7:0]    seq;
    iq_sample_t    head;
    iq_sample_t    sample_in;
    logic          unused_wr_bits;

    assign offset    = MEM_sdi_mem_S_address - BASE_ADDR;
    assign in_window = (offset[13:2] == '0);
    assign reg_sel   = offset[1:0];

    assign ctrl_wr   = MEM_sdi_mem_S_wrEn && in_window && (reg_sel == OFF_CTRL);
    assign flush     = ctrl_wr && MEM_sdi_mem_S_wrData[CTRL_FLUSH_BIT];
    assign ovf_clr   = ctrl_wr && MEM_sdi_mem_S_wrData[CTRL_OVF_CLR_BIT];
    assign head_q_rd = MEM_sdi_mem_S_rdEn && in_window && (reg_sel == OFF_HEAD_Q);

    assign not_empty = (count != '0);
    assign full      = (count == FULL_COUNT);

    // A same-cycle pop frees the slot, so a push into a full FIFO is accepted.
    assign do_pop    = head_q_rd && not_empty;
    assign do_push   = iq_valid && !flush && (!full || do_pop);
    assign ovf_event = iq_valid && !flush && full && !do_pop;

    assign sample_in = '{i: i_val, q: q_val};

    iq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .clear (flush),
        .din   (sample_in),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq        <= '0;
            overflow   <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            if (do_push) seq <= seq + 1'b1;
            // A new overflow event outranks a simultaneous clear request.
            overflow   <= ovf_event | (overflow & ~ovf_clr);
            data_ready <= (count_next != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_sdi_mem_M_rdData <= '0;
        end else if (MEM_sdi_mem_S_rdEn) begin
            if (!in_window) begin
                MEM_sdi_mem_M_rdData <= '0;
            end else begin
                case (reg_sel)
                    OFF_STATUS: MEM_sdi_mem_M_rdData <= pack_status(seq, overflow, 16'(count));
                    OFF_HEAD_I: MEM_sdi_mem_M_rdData <= not_empty ? {1'b1, head.i} : '0;
                    OFF_HEAD_Q: MEM_sdi_mem_M_rdData <= not_empty ? {1'b1, head.q} : '0;
                    default:    MEM_sdi_mem_M_rdData <= '0;
                endcase
            end
        end
    end

    assign unused_wr_bits = ^MEM_sdi_mem_S_wrData[32:2];

endmodule
